// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback, drives datapath controls.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3 cycles at zero wait; outputs decode combinationally from state.
// Backpressure: holds FETCH/MEMRD/MEMWR while mem_ready is low. MCU_JUMP_EN enables the JUMP state for OP_J.
module multicycle_control_unit #(
    parameter int              OP_W     = 6,
    parameter int              CNT_W    = 16,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'd0,
    parameter logic [OP_W-1:0] OP_LW    = 6'd35,
    parameter logic [OP_W-1:0] OP_SW    = 6'd43,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'd4,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'd8,
    parameter logic [OP_W-1:0] OP_J     = 6'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             iord,
    output logic             mem_re,
    output logic             mem_we,
    output logic             ir_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             rf_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`ifdef MCU_JUMP_EN
        ,
        S_JUMP   = 4'd12
`endif
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   retire;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j;

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_j     = (opcode == OP_J);

    assign state = cur_state;

    // State register and retired-instruction counter; reset clears both immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_IDLE;
            retired_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Moore output decode plus next-state selection; only FETCH's ir_we/pc_we look at mem_ready.
    always_comb begin
        nxt_state     = cur_state;
        retire        = 1'b0;
        pc_we         = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_re        = 1'b0;
        mem_we        = 1'b0;
        ir_we         = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        rf_we         = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        case (cur_state)
            S_IDLE: begin
                nxt_state = S_FETCH;
            end
            S_FETCH: begin
                // PC + 4 computed while the instruction is read; both commit only on the ready cycle.
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (mem_ready) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut so BRANCH can use it directly.
                alu_src_b = 2'b11;
                if (is_lw || is_sw) begin
                    nxt_state = S_MEMADR;
                end else if (is_rtype) begin
                    nxt_state = S_EXEC;
                end else if (is_beq) begin
                    nxt_state = S_BRANCH;
                end else if (is_addi) begin
                    nxt_state = S_ADDIEX;
`ifdef MCU_JUMP_EN
                end else if (is_j) begin
                    nxt_state = S_JUMP;
`else
                end else if (is_j) begin
                    // Jump support not built in: treat like any unknown opcode.
                    illegal_op = 1'b1;
                    nxt_state  = S_FETCH;
`endif
                end else begin
                    illegal_op = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = is_lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_re = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEMWR: begin
                mem_we = 1'b1;
                iord   = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we     = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                retire        = 1'b1;
                nxt_state     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we     = 1'b1;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                pc_we     = 1'b1;
                pc_src    = 2'b10;
                retire    = 1'b1;
                nxt_state = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings recover by restarting instruction fetch.
                nxt_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expectations queued by the stimulus, checked at negedge.
// Counter width set to 2 so the retired-instruction count wraps within the run.
// Honours MCU_JUMP_EN for the opcode-2 expectations.
module tb_multicycle_control_unit;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_we, pc_write_cond, iord, mem_re, mem_we, ir_we;
    logic             reg_dst, mem_to_reg, rf_we, alu_src_a, illegal_op;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic [CNT_W-1:0] retired_cnt;
    logic [3:0]       state;

    multicycle_control_unit #(.OP_W(6), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_we        (pc_we),
        .pc_write_cond(pc_write_cond),
        .pc_src       (pc_src),
        .iord         (iord),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .rf_we        (rf_we),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .illegal_op   (illegal_op),
        .retired_cnt  (retired_cnt),
        .state        (state)
    );

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               n_total = 0;
    int               n_bad   = 0;
    logic [CNT_W-1:0] cnt_m   = '0;
    logic [16:0]      ctrl_act;

    assign ctrl_act = {pc_we, pc_write_cond, pc_src, iord, mem_re, mem_we, ir_we,
                       reg_dst, mem_to_reg, rf_we, alu_src_a, alu_src_b, alu_op, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference control table, written per state from the state descriptions.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op, input logic rdy);
        logic       p_we = 0, p_wc = 0, i_d = 0, m_re = 0, m_we = 0, i_we = 0;
        logic       r_dst = 0, m2r = 0, r_we = 0, s_a = 0, ill = 0;
        logic [1:0] p_src = 0, s_b = 0, a_op = 0;
        logic       legal;
        legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd8);
`ifdef MCU_JUMP_EN
        legal = legal || (op == 6'd2);
`endif
        case (st)
            4'd1:  begin m_re = 1; s_b = 2'b01; i_we = rdy; p_we = rdy; end
            4'd2:  begin s_b = 2'b11; ill = !legal; end
            4'd3:  begin s_a = 1; s_b = 2'b10; end
            4'd4:  begin m_re = 1; i_d = 1; end
            4'd5:  begin r_we = 1; m2r = 1; end
            4'd6:  begin m_we = 1; i_d = 1; end
            4'd7:  begin s_a = 1; a_op = 2'b10; end
            4'd8:  begin r_we = 1; r_dst = 1; end
            4'd9:  begin s_a = 1; a_op = 2'b01; p_wc = 1; p_src = 2'b01; end
            4'd10: begin s_a = 1; s_b = 2'b10; end
            4'd11: begin r_we = 1; end
            4'd12: begin p_we = 1; p_src = 2'b10; end
            default: ;
        endcase
        return {p_we, p_wc, p_src, i_d, m_re, m_we, i_we, r_dst, m2r, r_we, s_a, s_b, a_op, ill};
    endfunction

    // One clock: drive mem_ready, queue what the DUT must show this cycle, advance.
    task automatic cyc(input logic [3:0] st, input logic rdy, input bit retire);
        exp_t e;
        mem_ready = rdy;
        e.st   = st;
        e.ctrl = exp_ctrl(st, opcode, rdy);
        e.cnt  = cnt_m;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (retire) cnt_m = cnt_m + 1'b1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Full instruction from FETCH, with wait cycles in FETCH and in the data access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        opcode = op;
        repeat (fw) cyc(4'd1, 1'b0, 0);
        cyc(4'd1, 1'b1, 0);
        cyc(4'd2, rnd(), 0);
        case (op)
            6'd0:  begin cyc(4'd7, rnd(), 0); cyc(4'd8, rnd(), 1); end
            6'd35: begin
                cyc(4'd3, rnd(), 0);
                repeat (mw) cyc(4'd4, 1'b0, 0);
                cyc(4'd4, 1'b1, 0);
                cyc(4'd5, rnd(), 1);
            end
            6'd43: begin
                cyc(4'd3, rnd(), 0);
                repeat (mw) cyc(4'd6, 1'b0, 0);
                cyc(4'd6, 1'b1, 1);
            end
            6'd4:  cyc(4'd9, rnd(), 1);
            6'd8:  begin cyc(4'd10, rnd(), 0); cyc(4'd11, rnd(), 1); end
`ifdef MCU_JUMP_EN
            6'd2:  cyc(4'd12, rnd(), 1);
`endif
            default: ;
        endcase
    endtask

    // Compare each queued expectation against the DUT away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("state", 32'(state), 32'(e.st));
            check("ctrl", 32'(ctrl_act), 32'(e.ctrl));
            check("retired_cnt", 32'(retired_cnt), 32'(e.cnt));
        end
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl_act), 32'd0);
        check("rst_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'd0, 1'b1, 0);

        run_instr(6'd0, 0, 0);    // R-type, no waits
        run_instr(6'd35, 0, 2);   // lw, two wait cycles in MEMRD
        run_instr(6'd43, 1, 0);   // sw, one wait cycle in FETCH
        run_instr(6'd63, 0, 0);   // illegal opcode
        run_instr(6'd2, 0, 0);    // jump or illegal depending on build
        run_instr(6'd4, 0, 0);    // beq; counter wraps around here
        run_instr(6'd8, 1, 0);    // addi
        run_instr(6'd0, 0, 0);

        // Reset in the middle of a stalled store.
        opcode = 6'd43;
        cyc(4'd1, 1'b1, 0);
        cyc(4'd2, 1'b0, 0);
        cyc(4'd3, 1'b0, 0);
        cyc(4'd6, 1'b0, 0);
        @(negedge clk);
        #2;
        check("pre_rst_mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_mem_we", 32'(mem_we), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_ctrl", 32'(ctrl_act), 32'd0);
        check("async_cnt", 32'(retired_cnt), 32'd0);
        cnt_m = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'd0, 1'b0, 0);
        run_instr(6'd0, 0, 0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);
        check("final_cnt", 32'(retired_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
